// File: rtl/utxd_crc_bl.sv
// UART reply-frame transmitter: com, lbl, adr_hi, adr_lo, [read data], CRC_lo, CRC_hi.
// Each byte: one prep clk, one load clk, then START/D0..D7/STOP at NT clks per bit.
module utxd_crc_bl #(
    parameter int          NT   = 4,
    parameter logic [15:0] INIT = 16'hFFFF,
    parameter logic [15:0] POLY = 16'h4002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_i,
    input  logic [7:0]  com_i,
    input  logic [7:0]  lbl_i,
    input  logic [15:0] adr_i,
    output logic [15:0] rd_adr_o,
    output logic        rd_en_o,
    input  logic [7:0]  rd_dat_i,
    output logic        utxd_o,
    output logic        busy_o,
    output logic [7:0]  cb_byte_o,
    output logic        ok_tx_bl_o
);
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;
    localparam logic [TW-1:0] TMR_LD = TW'(NT - 1);

    typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q;
    logic [7:0]    com_q, lbl_q, sh_q;
    logic [15:0]   adr_q, rd_adr_q, crc_q;
    logic [8:0]    cb_q, ndat_q;
    logic [2:0]    bit_q;
    logic [TW-1:0] tmr_q;
    logic          utxd_q, busy_q, rd_en_q, ok_q;

    logic          cmd_ok, tmr_done, is_dat, absorb, last, rd_nx;
    logic [8:0]    len, cb_nx;
    logic [7:0]    src;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? (((r ^ POLY) >> 1) | 16'h8000) : (r >> 1);
        return r;
    endfunction

    assign cmd_ok   = (com_i[7:1] == 7'h00) || (com_i[7:1] == 7'h40);
    assign tmr_done = (tmr_q == '0);
    assign len      = ndat_q + 9'd6;
    assign cb_nx    = cb_q + 9'd1;
    assign is_dat   = (cb_q >= 9'd4) && (cb_q < ndat_q + 9'd4);
    assign absorb   = (cb_q < len - 9'd2);
    assign last     = (cb_q == len - 9'd1);
    assign rd_nx    = (cb_nx >= 9'd4) && (cb_nx < ndat_q + 9'd4);

    always_comb begin
        src = crc_q[15:8];
        if (cb_q == 9'd0)             src = com_q;
        else if (cb_q == 9'd1)        src = lbl_q;
        else if (cb_q == 9'd2)        src = adr_q[15:8];
        else if (cb_q == 9'd3)        src = adr_q[7:0];
        else if (is_dat)              src = rd_dat_i;
        else if (cb_q == len - 9'd2)  src = crc_q[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            com_q    <= '0;
            lbl_q    <= '0;
            adr_q    <= '0;
            rd_adr_q <= '0;
            crc_q    <= INIT;
            cb_q     <= '0;
            ndat_q   <= '0;
            sh_q     <= '0;
            bit_q    <= '0;
            tmr_q    <= '0;
            utxd_q   <= 1'b1;
            busy_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            ok_q    <= 1'b0;
            // Line level follows the state one clk later, so st at edge k gives a falling edge at k+3.
            case (state_q)
                S_START: utxd_q <= 1'b0;
                S_DATA:  utxd_q <= sh_q[0];
                default: utxd_q <= 1'b1;
            endcase
            case (state_q)
                S_IDLE: begin
                    if (st_i && cmd_ok) begin
                        com_q    <= com_i;
                        lbl_q    <= lbl_i;
                        adr_q    <= adr_i;
                        rd_adr_q <= adr_i;
                        ndat_q   <= com_i[7] ? {1'b0, lbl_i} : 9'd0;
                        cb_q     <= '0;
                        crc_q    <= INIT;
                        busy_q   <= 1'b1;
                        state_q  <= S_P1;
                    end
                end
                S_P1: state_q <= S_P2;
                S_P2: begin
                    sh_q  <= src;
                    tmr_q <= TMR_LD;
                    if (absorb) crc_q <= crc_byte(crc_q, src);
                    if (is_dat) rd_adr_q <= rd_adr_q + 16'd1;
                    state_q <= S_START;
                end
                S_START: begin
                    if (tmr_done) begin
                        tmr_q   <= TMR_LD;
                        bit_q   <= '0;
                        state_q <= S_DATA;
                    end else tmr_q <= tmr_q - 1'b1;
                end
                S_DATA: begin
                    if (tmr_done) begin
                        tmr_q <= TMR_LD;
                        sh_q  <= sh_q >> 1;
                        if (bit_q == 3'd7) state_q <= S_STOP;
                        else               bit_q   <= bit_q + 3'd1;
                    end else tmr_q <= tmr_q - 1'b1;
                end
                S_STOP: begin
                    if (tmr_done) begin
                        if (last) begin
                            ok_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            cb_q    <= cb_nx;
                            rd_en_q <= rd_nx;
                            state_q <= S_P1;
                        end
                    end else tmr_q <= tmr_q - 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_adr_o   = rd_adr_q;
    assign rd_en_o    = rd_en_q;
    assign utxd_o     = utxd_q;
    assign busy_o     = busy_q;
    assign cb_byte_o  = cb_q[7:0];
    assign ok_tx_bl_o = ok_q;
endmodule

// File: tb/tb_utxd_crc_bl.sv
// Bench for utxd_crc_bl: UART decoder on the line, memory model, reference frame built
// from command fields with a table-free CRC-16 loop.
module tb_utxd_crc_bl;
    localparam int NT = 4;
    localparam int BT = 10 * NT + 2;

    logic        clk, rst, st;
    logic [7:0]  com, lbl, rd_dat, cb_byte;
    logic [15:0] adr, rd_adr;
    logic        rd_en, utxd, busy, ok;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    logic [15:0] rdadr_q[$];
    int          ok_cnt = 0, rden_cnt = 0;
    int          checks = 0, errors = 0;

    utxd_crc_bl #(.NT(NT), .INIT(16'hFFFF), .POLY(16'h4002)) dut (
        .clk(clk), .rst(rst), .st_i(st), .com_i(com), .lbl_i(lbl), .adr_i(adr),
        .rd_adr_o(rd_adr), .rd_en_o(rd_en), .rd_dat_i(rd_dat), .utxd_o(utxd),
        .busy_o(busy), .cb_byte_o(cb_byte), .ok_tx_bl_o(ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_dat <= mem[rd_adr];

    always @(negedge clk) begin
        if (ok) ok_cnt++;
        if (rd_en) begin
            rden_cnt++;
            rdadr_q.push_back(rd_adr);
        end
    end

    always begin : uart_mon
        logic [7:0] b;
        @(negedge clk);
        if (!rst && utxd === 1'b0) begin
            repeat (NT / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (NT) @(negedge clk);
                b[i] = utxd;
            end
            repeat (NT) @(negedge clk);
            if (utxd === 1'b1) rx_q.push_back(b);
        end
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    function automatic logic [15:0] rx_residue(input int start);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = start; i < rx_q.size(); i++) r = crc_step(r, rx_q[i]);
        return r;
    endfunction

    function automatic void build_exp(input logic [7:0] c, input logic [7:0] l, input logic [15:0] a);
        logic [15:0] r;
        exp_q.delete();
        exp_q.push_back(c);
        exp_q.push_back(l);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        if (c[7]) for (int i = 0; i < int'(l); i++) exp_q.push_back(mem[16'(a + 16'(i))]);
        r = 16'hFFFF;
        foreach (exp_q[i]) r = crc_step(r, exp_q[i]);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
    endfunction

    // mode 0: plain frame, 1: second st during byte 2, 2: reset pulse in D3 of byte 4
    task automatic run_frame(input logic [7:0] c, input logic [7:0] l, input logic [15:0] a,
                             input int mode, output int n);
        @(negedge clk);
        st = 1'b1; com = c; lbl = l; adr = a;
        @(posedge clk); #1;
        st = 1'b0;
        n = 0;
        while (n < 20000) begin
            @(posedge clk); #1;
            n++;
            if (mode == 1 && n == 2 * BT + 10) begin
                st = 1'b1; com = 8'h80; lbl = 8'h03; adr = 16'h5555;
            end else if (mode == 1 && n == 2 * BT + 11) st = 1'b0;
            if (mode == 2 && n == 4 * BT + 2 + 4 * NT + 1) rst = 1'b1;
            if (mode == 2 && n == 4 * BT + 2 + 4 * NT + 2) begin
                rst = 1'b0;
                break;
            end
            if (ok) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; st = 1'b1; com = 8'h80; lbl = 8'h02; adr = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({utxd, busy, rd_en, ok} !== 4'b1000 || rd_adr !== 16'h0 || cb_byte !== 8'h0) begin
            errors++;
            $display("FAIL reset: utxd=%b busy=%b rd_en=%b ok=%b rd_adr=%h cb=%h want 1 0 0 0 0000 00",
                     utxd, busy, rd_en, ok, rd_adr, cb_byte);
        end
        st = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins: busy=%b want 0", busy);
        end
    endtask

    task automatic test_frames();
        logic [7:0]  tc [8];
        logic [7:0]  tl [8];
        logic [15:0] ta [8];
        int n, rb, ab, r0, o0, nd, L;
        tc[0] = 8'h80; tl[0] = 8'd2; ta[0] = 16'h12FF;
        tc[1] = 8'h01; tl[1] = 8'd5; ta[1] = 16'hABCD;
        tc[2] = 8'h81; tl[2] = 8'd0; ta[2] = 16'hFFFF;
        for (int t = 3; t < 8; t++) begin
            tc[t] = 8'($urandom_range(0, 3));
            tc[t] = {tc[t][1], 6'b0, tc[t][0]};
            tl[t] = 8'($urandom_range(0, 6));
            ta[t] = 16'($urandom);
        end
        for (int t = 0; t < 8; t++) begin
            build_exp(tc[t], tl[t], ta[t]);
            nd = tc[t][7] ? int'(tl[t]) : 0;
            L  = exp_q.size();
            rb = rx_q.size(); ab = rdadr_q.size(); r0 = rden_cnt; o0 = ok_cnt;
            run_frame(tc[t], tl[t], ta[t], 0, n);
            repeat (10) @(negedge clk);
            checks++;
            if (n !== L * BT) begin
                errors++;
                $display("FAIL duration[%0d]: got %0d clks want %0d", t, n, L * BT);
            end
            checks++;
            if (rx_q.size() - rb !== L) begin
                errors++;
                $display("FAIL length[%0d]: got %0d bytes want %0d", t, rx_q.size() - rb, L);
            end else begin
                for (int i = 0; i < L; i++) begin
                    checks++;
                    if (rx_q[rb + i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL byte[%0d][%0d]: got %h want %h", t, i, rx_q[rb + i], exp_q[i]);
                    end
                end
                checks++;
                if (rx_residue(rb) !== 16'h0000) begin
                    errors++;
                    $display("FAIL residue[%0d]: got %h want 0000", t, rx_residue(rb));
                end
            end
            checks++;
            if (rden_cnt - r0 !== nd) begin
                errors++;
                $display("FAIL rd_en_count[%0d]: got %0d want %0d", t, rden_cnt - r0, nd);
            end else begin
                for (int i = 0; i < nd; i++) begin
                    checks++;
                    if (rdadr_q[ab + i] !== 16'(ta[t] + 16'(i))) begin
                        errors++;
                        $display("FAIL rd_adr[%0d][%0d]: got %h want %h", t, i, rdadr_q[ab + i],
                                 16'(ta[t] + 16'(i)));
                    end
                end
            end
            checks++;
            if (ok_cnt - o0 !== 1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done[%0d]: ok pulses %0d busy %b want 1 0", t, ok_cnt - o0, busy);
            end
        end
    endtask

    task automatic test_bad_com();
        int o0, bad;
        o0 = ok_cnt; bad = 0;
        @(negedge clk);
        st = 1'b1; com = 8'h42; lbl = 8'd3; adr = 16'h0100;
        @(negedge clk);
        st = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || utxd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || ok_cnt != o0) begin
            errors++;
            $display("FAIL bad_com: %0d active clks, %0d ok pulses, want 0 0", bad, ok_cnt - o0);
        end
    endtask

    task automatic test_back_to_back();
        int n, rb, o0;
        build_exp(8'h80, 8'd2, 16'h0040);
        rb = rx_q.size(); o0 = ok_cnt;
        run_frame(8'h80, 8'd2, 16'h0040, 1, n);
        repeat (300) @(negedge clk);
        checks++;
        if (rx_q.size() - rb !== exp_q.size() || ok_cnt - o0 !== 1) begin
            errors++;
            $display("FAIL st_while_busy: %0d bytes %0d ok pulses, want %0d 1",
                     rx_q.size() - rb, ok_cnt - o0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[rb + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL st_while_busy_byte[%0d]: got %h want %h", i, rx_q[rb + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, rb, o0;
        o0 = ok_cnt;
        run_frame(8'h81, 8'd4, 16'h2000, 2, n);
        checks++;
        if (utxd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: utxd=%b busy=%b want 1 0", utxd, busy);
        end
        repeat (100) @(negedge clk);
        checks++;
        if (ok_cnt != o0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: ok pulses %0d busy %b want 0 0", ok_cnt - o0, busy);
        end
        build_exp(8'h80, 8'd3, 16'h3FFE);
        rb = rx_q.size(); o0 = ok_cnt;
        run_frame(8'h80, 8'd3, 16'h3FFE, 0, n);
        repeat (10) @(negedge clk);
        checks++;
        if (rx_q.size() - rb !== exp_q.size() || ok_cnt - o0 !== 1 || n !== exp_q.size() * BT) begin
            errors++;
            $display("FAIL after_reset: %0d bytes %0d ok %0d clks, want %0d 1 %0d",
                     rx_q.size() - rb, ok_cnt - o0, n, exp_q.size(), exp_q.size() * BT);
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_q[rb + i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL after_reset_byte[%0d]: got %h want %h", i, rx_q[rb + i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[16'h12FF] = 8'hA5;
        mem[16'h1300] = 8'h3C;
        rst = 1'b1; st = 1'b0; com = 8'h00; lbl = 8'h00; adr = 16'h0000;
        test_reset();
        test_frames();
        test_bad_com();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
